bypass_stream_checker: RTL
==========================

// Module: bypass_stream_checker
// PURPOSE
//   Downstream consumer of the dual-channel data bypass. Takes the golden stream (new channel) and the
//   checked stream (legacy channel) and buffers each in its own FIFO. Pops the two in lock-step and compares them in order.
//   Reports per-compare results, saturating match/mismatch counters, first-mismatch capture and FIFO overflow flags.
//   No backpressure toward the bypass: arrival skew between the channels is absorbed by the FIFOs.
// PARAMETERS
//   DATA_W      64   width of both data streams
//   FIFO_DEPTH  8    entries per channel FIFO; power of two, >=2
//   CNT_W       32   width of match/mismatch/compare-index counters
// PORTS
//   clk            in   1            clock
//   rst_n          in   1            reset, asynchronous, active-low
//   clear          in   1            sync clear of FIFOs, counters, sticky flags
//   ref_valid      in   1            golden beat valid (from data_out_valid_new)
//   ref_data       in   DATA_W       golden beat data
//   dut_valid      in   1            checked beat valid (from data_out_valid)
//   dut_data       in   DATA_W       checked beat data
//   cmp_valid      out  1            one-cycle pulse: a compare result is presented
//   cmp_match      out  1            result of that compare (1 = equal)
//   cmp_ref_data   out  DATA_W       golden word of that compare
//   cmp_dut_data   out  DATA_W       checked word of that compare
//   match_cnt      out  CNT_W        total matching compares, saturating
//   mismatch_cnt   out  CNT_W        total mismatching compares, saturating
//   err_sticky     out  1            set on first mismatch, held until clear/reset
//   first_err_idx  out  CNT_W        0-based compare index of first mismatch
//   first_err_ref  out  DATA_W       golden word of first mismatch
//   first_err_dut  out  DATA_W       checked word of first mismatch
//   ref_ovf        out  1            sticky: golden beat dropped on full FIFO
//   dut_ovf        out  1            sticky: checked beat dropped on full FIFO
//   ref_level      out  log2(D)+1    golden FIFO occupancy
//   dut_level      out  log2(D)+1    checked FIFO occupancy
// BEHAVIOUR
// - Reset: all outputs 0, both FIFOs empty, internal compare index 0.
// - Push: at each edge with X_valid=1, X_data is written to the X FIFO. Data is ignored when valid=0.
// - Pop: at each edge where both FIFOs are non-empty (pre-edge occupancy), both heads pop together.
//   The comparison is registered at that edge.
//   - cmp_valid=1 for exactly the following cycle, with cmp_match/cmp_ref_data/cmp_dut_data.
//   - cmp_* data outputs hold their last value while cmp_valid=0.
// - Latency: both beats sampled at edge N on empty FIFOs -> pop at edge N+1 -> cmp_valid high in cycle after N+1.
//   Streaming throughput is one compare per cycle.
// - Ordering: strict FIFO order per channel; the k-th golden beat is always compared with the k-th checked beat.
// - Full + push + pop same edge: the pop frees a slot and the push is accepted. Level is unchanged. No overflow.
// - Full + push without pop: the beat is dropped and the FIFO is unchanged. X_ovf is set (sticky). Compares continue.
// - Empty + push: the beat is not compared in the same edge (no fall-through).
// - Counters:
//   - match_cnt or mismatch_cnt increments at the same edge that raises cmp_valid.
//   - Both counters saturate at all-ones.
//   - The internal compare index increments per compare and wraps.
// - First error: on the first mismatch while err_sticky=0, capture index/ref/dut at that edge and set err_sticky.
//   first_err_* are frozen until clear or reset.
// - clear=1 at an edge:
//   - Empties both FIFOs; zeroes counters, index, err_sticky, first_err_*, *_ovf.
//   - Forces cmp_valid=0 next cycle.
//   - Pushes sampled in that same edge are discarded.
//   - clear has priority over every other event.
// - Reset mid-stream: asynchronous. Outputs go to reset values immediately. Beats in flight are lost.
// - Levels: range 0..FIFO_DEPTH inclusive, updated at each edge from push/pop accounting.
// TESTING
// - Reset, then 10 identical beats on both inputs in the same cycles (0x0..0x9).
//   -> 10 cmp_valid pulses, all cmp_match=1.
//   -> match_cnt=10, mismatch_cnt=0, err_sticky=0, levels 0 at end.
// - Golden beats 0xA0..0xA3 sent 5 cycles before the checked beats 0xA0..0xA3.
//   -> ref_level peaks at 4, then 4 matches in order, no overflow.
// - Checked beat #2 = 0xFFFF_FFFF_FFFF_FFFF vs golden 0x2, beat #5 also corrupted.
//   -> mismatch_cnt=2, err_sticky=1, first_err_idx=2.
//   -> first_err_ref=0x2, first_err_dut=all-ones; the capture is unchanged by beat #5.
// - FIFO_DEPTH=8: 10 golden beats, checked stream idle.
//   -> ref_level=8, ref_ovf=1, beats 9-10 dropped.
//   -> Then 8 checked beats of matching values give 8 matches.
// - Both FIFOs full with a push on both and a pop in the same edge.
//   -> Levels stay 8, no ovf, and the order is preserved.
// - Mid-stream clear with 3 beats queued plus a same-cycle push.
//   -> Levels 0, counters 0, err_sticky 0, no cmp_valid next cycle.
//   -> rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bypass_stream_checker.sv
// Lock-step comparator for the dual-channel bypass: the golden and checked
// streams each go into their own FIFO, pairs pop together and are compared
// in order. Provides per-compare results, saturating counters, first-mismatch
// capture and sticky overflow flags.

// Per-channel FIFO. The head word is read combinationally. push/pop are
// accounted at the same edge, so a full FIFO accepts a push when it also pops.
module bsc_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       wr_data,
   output logic [DATA_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              accept;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign accept  = push && (!full || pop);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear overrides any push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(accept) - (AW+1)'(pop);
      end
   end

   // Storage write; needs no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (accept && !clear) mem[wr_ptr] <= wr_data;
   end
endmodule

module bypass_stream_checker #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          ref_valid,
   input  logic [DATA_W-1:0]             ref_data,
   input  logic                          dut_valid,
   input  logic [DATA_W-1:0]             dut_data,
   output logic                          cmp_valid,
   output logic                          cmp_match,
   output logic [DATA_W-1:0]             cmp_ref_data,
   output logic [DATA_W-1:0]             cmp_dut_data,
   output logic [CNT_W-1:0]              match_cnt,
   output logic [CNT_W-1:0]              mismatch_cnt,
   output logic                          err_sticky,
   output logic [CNT_W-1:0]              first_err_idx,
   output logic [DATA_W-1:0]             first_err_ref,
   output logic [DATA_W-1:0]             first_err_dut,
   output logic                          ref_ovf,
   output logic                          dut_ovf,
   output logic [$clog2(FIFO_DEPTH):0]   ref_level,
   output logic [$clog2(FIFO_DEPTH):0]   dut_level
);
   logic [DATA_W-1:0] ref_head;
   logic [DATA_W-1:0] dut_head;
   logic              ref_full;
   logic              ref_empty;
   logic              dut_full;
   logic              dut_empty;
   logic              pop;
   logic              heads_eq;
   logic [CNT_W-1:0]  cmp_idx;

   // Pop only with both heads present; clear suppresses the pop entirely.
   assign pop      = !ref_empty && !dut_empty && !clear;
   assign heads_eq = (ref_head == dut_head);

   bsc_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push    (ref_valid),
      .pop     (pop),
      .wr_data (ref_data),
      .rd_data (ref_head),
      .level   (ref_level),
      .full    (ref_full),
      .empty   (ref_empty)
   );

   bsc_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_dut_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push    (dut_valid),
      .pop     (pop),
      .wr_data (dut_data),
      .rd_data (dut_head),
      .level   (dut_level),
      .full    (dut_full),
      .empty   (dut_empty)
   );

   // Sticky overflow: a beat arriving on a full FIFO that is not popping is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_ovf <= 1'b0;
         dut_ovf <= 1'b0;
      end else if (clear) begin
         ref_ovf <= 1'b0;
         dut_ovf <= 1'b0;
      end else begin
         if (ref_valid && ref_full && !pop) ref_ovf <= 1'b1;
         if (dut_valid && dut_full && !pop) dut_ovf <= 1'b1;
      end
   end

   // Registered compare result; data/match outputs hold between compares.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_valid    <= 1'b0;
         cmp_match    <= 1'b0;
         cmp_ref_data <= '0;
         cmp_dut_data <= '0;
      end else begin
         cmp_valid <= pop;
         if (pop) begin
            cmp_match    <= heads_eq;
            cmp_ref_data <= ref_head;
            cmp_dut_data <= dut_head;
         end
      end
   end

   // Saturating counters, wrapping compare index and first-mismatch capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt     <= '0;
         mismatch_cnt  <= '0;
         cmp_idx       <= '0;
         err_sticky    <= 1'b0;
         first_err_idx <= '0;
         first_err_ref <= '0;
         first_err_dut <= '0;
      end else if (clear) begin
         match_cnt     <= '0;
         mismatch_cnt  <= '0;
         cmp_idx       <= '0;
         err_sticky    <= 1'b0;
         first_err_idx <= '0;
         first_err_ref <= '0;
         first_err_dut <= '0;
      end else if (pop) begin
         cmp_idx <= cmp_idx + 1'b1;
         if (heads_eq) begin
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
         end else begin
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!err_sticky) begin
               err_sticky    <= 1'b1;
               first_err_idx <= cmp_idx;
               first_err_ref <= ref_head;
               first_err_dut <= dut_head;
            end
         end
      end
   end
endmodule
